// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the MIPS core: loads the boot PC, waits a settle interval, enables the core,
// then watches for a branch-to-self halt or cycle-budget exhaustion. All outputs registered.
module cpu_run_ctrl #(
  parameter logic [31:0] BOOT_ADDR     = 32'h0040_0020,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          HALT_REPEAT   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] boot_addr,
  input  logic [31:0] max_cycles,
  input  logic [31:0] cpu_pc,
  output logic        pc_ld,
  output logic [31:0] pc_data,
  output logic        run_en,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE} state_t;

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] HALT_N      = 32'(HALT_REPEAT);

  state_t      state_q, state_d;
  logic        pc_ld_q, pc_ld_d;
  logic [31:0] pc_data_q, pc_data_d;
  logic        run_en_q, run_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timed_out_q, timed_out_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] max_cycles_q, max_cycles_d;
  logic [31:0] settle_q, settle_d;
  logic [31:0] stable_q, stable_d;
  logic [31:0] prev_pc_q, prev_pc_d;

  logic [31:0] count_inc;
  logic        first_run;
  logic        pc_same;
  logic        halt_hit;
  logic        budget_hit;

  always_comb begin
    state_d       = state_q;
    pc_data_d     = pc_data_q;
    done_d        = done_q;
    timed_out_d   = timed_out_q;
    cycle_count_d = cycle_count_q;
    max_cycles_d  = max_cycles_q;
    settle_d      = settle_q;
    stable_d      = stable_q;
    prev_pc_d     = prev_pc_q;

    count_inc  = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
    // The count is cleared on every accepted start and saturates, so zero marks the first RUN cycle.
    first_run  = (cycle_count_q == 32'd0);
    pc_same    = (cpu_pc == prev_pc_q);
    halt_hit   = !first_run && pc_same && ((stable_q + 32'd1) == HALT_N);
    budget_hit = (max_cycles_q != 32'd0) && (count_inc == max_cycles_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_data_d     = boot_addr;
          max_cycles_d  = max_cycles;
          done_d        = 1'b0;
          timed_out_d   = 1'b0;
          cycle_count_d = 32'd0;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        settle_d = 32'd0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        stable_d = 32'd0;
        if (settle_q >= SETTLE_LAST) state_d = S_RUN;
        else                         settle_d = settle_q + 32'd1;
      end
      S_RUN: begin
        cycle_count_d = count_inc;
        prev_pc_d     = cpu_pc;
        stable_d      = (!first_run && pc_same) ? stable_q + 32'd1 : 32'd0;
        if (halt_hit) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          timed_out_d = 1'b0;
        end else if (budget_hit) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort still counts the RUN cycle it lands in; only the state and flags are unwound.
    if (abort && (state_q == S_LOAD || state_q == S_SETTLE || state_q == S_RUN)) begin
      state_d     = S_IDLE;
      done_d      = 1'b0;
      timed_out_d = 1'b0;
    end

    pc_ld_d  = (state_d == S_LOAD);
    run_en_d = (state_d == S_RUN);
    busy_d   = (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_ld_q       <= 1'b0;
      pc_data_q     <= BOOT_ADDR;
      run_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      cycle_count_q <= 32'd0;
      max_cycles_q  <= 32'd0;
      settle_q      <= 32'd0;
      stable_q      <= 32'd0;
      prev_pc_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_ld_q       <= pc_ld_d;
      pc_data_q     <= pc_data_d;
      run_en_q      <= run_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timed_out_q   <= timed_out_d;
      cycle_count_q <= cycle_count_d;
      max_cycles_q  <= max_cycles_d;
      settle_q      <= settle_d;
      stable_q      <= stable_d;
      prev_pc_q     <= prev_pc_d;
    end
  end

  assign pc_ld       = pc_ld_q;
  assign pc_data     = pc_data_q;
  assign run_en      = run_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Sequencer that brings up and supervises the MIPS CPU core for a test run.
- Loads the boot PC through the core's pc_ld/pc_data load path, waits a settle interval, then asserts the run enable (the core's clockthing input).
- While running, counts cycles and detects program end: either the PC sits on a branch-to-self, or a cycle budget runs out.
- Replaces hand-timed pc_ld/clockthing/$stop sequencing in benches and gives the core a reusable run controller.

Parameters:
- BOOT_ADDR, 32'h0040_0020: reset value of pc_data; the conventional program entry.
- SETTLE_CYCLES, 2: cycles between the pc_ld pulse and run_en rising; minimum 1.
- HALT_REPEAT, 3: consecutive cycles cpu_pc must equal its previous value to declare a halt; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; level, sampled each edge.
- abort  in  1  stop the current run immediately.
- boot_addr  in  32  PC to load; captured on an accepted start.
- max_cycles  in  32  cycle budget; captured on an accepted start; 0 = unlimited.
- cpu_pc  in  32  current PC observed from the core.
- pc_ld  out  1  one-cycle PC load strobe to the core.
- pc_data  out  32  PC load value to the core.
- run_en  out  1  core run/clock enable (drives clockthing).
- busy  out  1  high in LOAD, SETTLE and RUN.
- done  out  1  run finished (halt or timeout); sticky.
- timed_out  out  1  run ended on budget exhaustion; sticky.
- cycle_count  out  32  number of cycles with run_en=1 in this run.

Behaviour:
- All outputs are registered.
- Reset values (asynchronous, on rst_n low):
  - state=IDLE; pc_ld=0; pc_data=BOOT_ADDR; run_en=0; busy=0; done=0; timed_out=0; cycle_count=0.
  - Internal stable counter and prev_pc cleared.
- States: IDLE, LOAD, SETTLE, RUN, DONE.
- IDLE/DONE, start=1 at an edge:
  - Capture boot_addr into pc_data and max_cycles into the budget register.
  - Clear done, timed_out and cycle_count; go to LOAD.
  - pc_ld and busy are 1 in the following cycle.
- LOAD: exactly 1 cycle with pc_ld=1, then SETTLE. pc_data stays stable from LOAD through the end of the run.
- SETTLE: pc_ld=0, run_en=0 for SETTLE_CYCLES cycles, then RUN.
- RUN:
  - run_en=1. cycle_count increments each RUN cycle and saturates at 32'hFFFF_FFFF.
  - First RUN cycle: load prev_pc <- cpu_pc, stable=0, no compare.
  - Later cycles:
    - If cpu_pc==prev_pc, stable++; otherwise stable=0.
    - prev_pc <- cpu_pc every cycle.
  - Halt: a compare makes stable reach HALT_REPEAT. Next state is DONE with done=1 and timed_out=0.
  - Timeout: max_cycles!=0 and the post-increment cycle_count==max_cycles. Next state is DONE with done=1 and timed_out=1.
  - Halt and timeout on the same edge: halt wins, so timed_out=0.
- DONE: run_en=0, busy=0, cycle_count frozen. done and timed_out hold until the next accepted start.
- start while busy: ignored; captured operands unchanged.
- abort=1 in LOAD, SETTLE or RUN:
  - Next state IDLE; run_en=0 and pc_ld=0 from the next cycle.
  - done=0, timed_out=0; cycle_count holds its value.
- abort in IDLE/DONE: no effect.
- abort and start on the same edge: abort has priority, and start is ignored that edge.
- rst_n falling mid-run: run_en and pc_ld drop immediately, asynchronously, and all state returns to reset values.
- Latency: an accepted start at edge k gives pc_ld high in cycle k+1 and run_en high from cycle k+2+SETTLE_CYCLES.

Test Plan:
- Reset then start with defaults, boot_addr=32'h0040_0020, max_cycles=0 -> pc_ld high exactly 1 cycle with pc_data=32'h0040_0020; run_en rises 3 cycles after pc_ld; busy=1 throughout.
- Halt: cpu_pc steps +4 for 10 cycles, then holds 32'h0040_0060 -> done=1 and timed_out=0 on the edge after the 3rd equal compare; cycle_count=14; run_en=0 thereafter.
- Timeout: max_cycles=5 with cpu_pc always incrementing -> run_en high exactly 5 cycles; done=1, timed_out=1, cycle_count=5.
- Simultaneous: max_cycles set so the budget expires on the same edge the halt is detected -> done=1, timed_out=0.
- Abort and start interaction:
  - abort in cycle 3 of RUN -> IDLE next cycle, run_en=0, done=0, cycle_count=3.
  - start asserted during RUN -> ignored, and pc_data unchanged.
- Async reset: drop rst_n mid-RUN between clock edges -> run_en=0, pc_data=BOOT_ADDR and cycle_count=0 immediately, with no clock edge required.
